// File: rtl/instr_loader_if.sv
// Purpose: host-stream / instruction-memory write bundle for instr_loader.
// Signals:
//   start, in_valid, in_data[W], in_last          host -> loader
//   in_ready                                      loader -> host
//   wr_en, wr_addr[D], wr_data[W]                 loader -> instruction RAM write port
//   load_count[D+1], loading, load_done,
//   core_start, overflow                          loader -> core / status
// Modports: slave = loader view, master = host/driver view.
interface instr_loader_if #(
  parameter int D = 12,
  parameter int W = 9
);
  logic         start;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_ready;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic [D:0]   load_count;
  logic         loading;
  logic         load_done;
  logic         core_start;
  logic         overflow;

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data, load_count,
           loading, load_done, core_start, overflow
  );

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data, load_count,
           loading, load_done, core_start, overflow
  );
endinterface

// File: rtl/instr_loader.sv
// Purpose: writer side of the instruction store. Accepts W-bit machine words from
// a host stream and writes them in order from address 0 into the instruction RAM
// write port; pulses core_start once the last word is stored and raises a sticky
// overflow flag if the program is longer than 2**D words.
// Ports:
//   clk_i      rising-edge clock
//   reset_n_i  synchronous reset, active-low
//   bus_io     instr_loader_if.slave (host stream, RAM write port, status)
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LOAD   | accepting words, one RAM write per handshake
// DONE   | program stored; core_start on first cycle, load_done held
// ERR    | program exceeded memory depth; overflow held, nothing accepted
module instr_loader #(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  instr_loader_if.slave     bus_io
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_e;

  localparam logic [D-1:0] ADDR_MAX = '1;

  state_e       state_q, state_d;
  logic [D-1:0] addr_q, addr_d;
  logic [D:0]   cnt_q, cnt_d;
  logic         wr_en_q, wr_en_d;
  logic [D-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0] wr_data_q, wr_data_d;
  logic         ovf_q, ovf_d;
  logic         cs_q, cs_d;
  logic         hs;

  assign hs = bus_io.in_valid && (state_q == S_LOAD);

  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
      cs_q      <= cs_d;
    end
  end

  // next-state
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q;
    cs_d      = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = bus_io.in_data;
          cnt_d     = cnt_q + 1'b1;
          // the last slot is never followed by a wrap back to 0
          if (addr_q != ADDR_MAX) addr_d = addr_q + 1'b1;
          // in_last takes priority so a program exactly filling memory completes
          if (bus_io.in_last) begin
            state_d = S_DONE;
            cs_d    = 1'b1;
          end else if (addr_q == ADDR_MAX) begin
            state_d = S_ERR;
            ovf_d   = 1'b1;
          end
        end
      end
      default: begin
        if (bus_io.start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
    endcase
  end

  // outputs
  always_comb begin
    bus_io.in_ready   = (state_q == S_LOAD);
    bus_io.loading    = (state_q == S_LOAD);
    bus_io.load_done  = (state_q == S_DONE);
    bus_io.overflow   = ovf_q;
    bus_io.core_start = cs_q;
    bus_io.wr_en      = wr_en_q;
    bus_io.wr_addr    = wr_addr_q;
    bus_io.wr_data    = wr_data_q;
    bus_io.load_count = cnt_q;
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_loader_if #(.D(12), .W(9)) ia ();
  instr_loader_if #(.D(2),  .W(9)) ib ();

  instr_loader #(.D(12), .W(9)) dut_a (.clk_i(clk), .reset_n_i(reset_n), .bus_io(ia.slave));
  instr_loader #(.D(2),  .W(9)) dut_b (.clk_i(clk), .reset_n_i(reset_n), .bus_io(ib.slave));

  int checks = 0;
  int errors = 0;

  logic [20:0] qa[$];
  logic [10:0] qb[$];
  logic [20:0] ea;
  logic [10:0] eb;
  logic [8:0]  prog [3] = '{9'h07E, 9'h066, 9'h1DE};

  // write scoreboards: every observed write must match the oldest expected one
  always @(negedge clk) begin
    if (ia.wr_en === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_write: unexpected write addr=%0h data=%0h, expected no write", ia.wr_addr, ia.wr_data);
      end else begin
        ea = qa.pop_front();
        if ({ia.wr_addr, ia.wr_data} !== ea) begin
          errors++;
          $display("FAIL a_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   ia.wr_addr, ia.wr_data, ea[20:9], ea[8:0]);
        end
      end
    end
    if (ib.wr_en === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_write: unexpected write addr=%0h data=%0h, expected no write", ib.wr_addr, ib.wr_data);
      end else begin
        eb = qb.pop_front();
        if ({ib.wr_addr, ib.wr_data} !== eb) begin
          errors++;
          $display("FAIL b_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   ib.wr_addr, ib.wr_data, eb[10:9], eb[8:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic s, input logic v, input logic [8:0] d, input logic l);
    ia.start = s; ia.in_valid = v; ia.in_data = d; ia.in_last = l;
  endtask

  task automatic set_b(input logic s, input logic v, input logic [8:0] d, input logic l);
    ib.start = s; ib.in_valid = v; ib.in_data = d; ib.in_last = l;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    set_a(0, 0, 9'h0, 0);
    set_b(0, 0, 9'h0, 0);
    tick; tick;
    checks++;
    if ({ia.in_ready, ia.wr_en, ia.wr_addr, ia.wr_data, ia.load_count, ia.loading,
         ia.load_done, ia.core_start, ia.overflow} !== '0) begin
      errors++;
      $display("FAIL reset_a_outputs: got %0h expected 0",
               {ia.in_ready, ia.wr_en, ia.wr_addr, ia.wr_data, ia.load_count, ia.loading,
                ia.load_done, ia.core_start, ia.overflow});
    end
    checks++;
    if ({ib.in_ready, ib.wr_en, ib.wr_addr, ib.wr_data, ib.load_count, ib.loading,
         ib.load_done, ib.core_start, ib.overflow} !== '0) begin
      errors++;
      $display("FAIL reset_b_outputs: got %0h expected 0",
               {ib.in_ready, ib.wr_en, ib.wr_addr, ib.wr_data, ib.load_count, ib.loading,
                ib.load_done, ib.core_start, ib.overflow});
    end
    // words offered while idle must be ignored
    reset_n = 1'b1;
    set_a(0, 1, 9'h155, 1);
    tick; tick;
    checks++;
    if (ia.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_in_ready: got %0b expected 0", ia.in_ready);
    end
    checks++;
    if (ia.loading !== 1'b0) begin
      errors++;
      $display("FAIL idle_loading: got %0b expected 0", ia.loading);
    end
    set_a(0, 0, 9'h0, 0);
    tick;
  endtask

  task automatic test_back_to_back;
    set_a(1, 0, 9'h0, 0);
    tick;
    checks++;
    if (ia.in_ready !== 1'b1 || ia.loading !== 1'b1) begin
      errors++;
      $display("FAIL b2b_enter_load: got ready=%0b loading=%0b expected 1 1", ia.in_ready, ia.loading);
    end
    for (int i = 0; i < 3; i++) begin
      set_a(0, 1, prog[i], i == 2);
      qa.push_back({12'(i), prog[i]});
      tick;
      if (i < 2) begin
        checks++;
        if (ia.core_start !== 1'b0) begin
          errors++;
          $display("FAIL b2b_early_core_start: got %0b expected 0 at word %0d", ia.core_start, i);
        end
      end
    end
    set_a(0, 0, 9'h0, 0);
    checks++;
    if (ia.core_start !== 1'b1 || ia.load_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got core_start=%0b load_done=%0b expected 1 1", ia.core_start, ia.load_done);
    end
    checks++;
    if (ia.load_count !== 13'd3) begin
      errors++;
      $display("FAIL b2b_load_count: got %0d expected 3", ia.load_count);
    end
    tick;
    checks++;
    if (ia.core_start !== 1'b0 || ia.load_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pulse_width: got core_start=%0b load_done=%0b expected 0 1", ia.core_start, ia.load_done);
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL b2b_writes_missing: got %0d pending expected 0", qa.size());
    end
  endtask

  task automatic test_gapped;
    set_a(1, 0, 9'h0, 0);
    tick;
    checks++;
    if (ia.load_done !== 1'b0 || ia.load_count !== 13'd0 || ia.loading !== 1'b1) begin
      errors++;
      $display("FAIL gap_restart: got done=%0b count=%0d loading=%0b expected 0 0 1",
               ia.load_done, ia.load_count, ia.loading);
    end
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin
        set_a(0, 1, prog[i/2], i == 4);
        qa.push_back({12'(i/2), prog[i/2]});
      end else begin
        set_a(0, 0, 9'h1FF, 1);
      end
      tick;
    end
    set_a(0, 0, 9'h0, 0);
    checks++;
    if (ia.core_start !== 1'b1 || ia.load_count !== 13'd3) begin
      errors++;
      $display("FAIL gap_done: got core_start=%0b count=%0d expected 1 3", ia.core_start, ia.load_count);
    end
    tick;
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL gap_writes_missing: got %0d pending expected 0", qa.size());
    end
  endtask

  task automatic test_overflow;
    set_b(1, 0, 9'h0, 0);
    tick;
    for (int i = 0; i < 5; i++) begin
      set_b(0, 1, 9'(9'h040 + i), 0);
      if (i < 4) qb.push_back({2'(i), 9'(9'h040 + i)});
      tick;
      checks++;
      if (ib.core_start !== 1'b0) begin
        errors++;
        $display("FAIL ovf_core_start: got %0b expected 0 at word %0d", ib.core_start, i);
      end
      if (i == 3) begin
        checks++;
        if (ib.overflow !== 1'b1 || ib.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL ovf_enter_err: got overflow=%0b ready=%0b expected 1 0", ib.overflow, ib.in_ready);
        end
      end
    end
    checks++;
    if (ib.load_count !== 3'd4 || ib.overflow !== 1'b1 || ib.load_done !== 1'b0) begin
      errors++;
      $display("FAIL ovf_hold: got count=%0d overflow=%0b done=%0b expected 4 1 0",
               ib.load_count, ib.overflow, ib.load_done);
    end
    set_b(1, 0, 9'h0, 0);
    tick;
    checks++;
    if (ib.overflow !== 1'b0 || ib.loading !== 1'b1 || ib.load_count !== 3'd0) begin
      errors++;
      $display("FAIL ovf_restart: got overflow=%0b loading=%0b count=%0d expected 0 1 0",
               ib.overflow, ib.loading, ib.load_count);
    end
    set_b(0, 1, 9'h0AA, 1);
    qb.push_back({2'd0, 9'h0AA});
    tick;
    set_b(0, 0, 9'h0, 0);
    checks++;
    if (ib.core_start !== 1'b1 || ib.load_done !== 1'b1 || ib.load_count !== 3'd1 || ib.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_reload_done: got cs=%0b done=%0b count=%0d ovf=%0b expected 1 1 1 0",
               ib.core_start, ib.load_done, ib.load_count, ib.overflow);
    end
    tick;
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL ovf_writes_missing: got %0d pending expected 0", qb.size());
    end
  endtask

  task automatic test_full_memory;
    set_b(1, 0, 9'h0, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      set_b(0, 1, 9'(9'h1C0 + i), i == 3);
      qb.push_back({2'(i), 9'(9'h1C0 + i)});
      tick;
    end
    set_b(0, 0, 9'h0, 0);
    checks++;
    if (ib.load_done !== 1'b1 || ib.core_start !== 1'b1 || ib.load_count !== 3'd4 || ib.overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_done: got done=%0b cs=%0b count=%0d ovf=%0b expected 1 1 4 0",
               ib.load_done, ib.core_start, ib.load_count, ib.overflow);
    end
    tick;
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL full_writes_missing: got %0d pending expected 0", qb.size());
    end
  endtask

  task automatic test_reset_mid_load;
    set_a(1, 0, 9'h0, 0);
    tick;
    set_a(0, 1, 9'h011, 0);
    qa.push_back({12'd0, 9'h011});
    tick;
    set_a(0, 1, 9'h022, 0);
    qa.push_back({12'd1, 9'h022});
    tick;
    // reset and start on the same edge: reset must win
    reset_n = 1'b0;
    set_a(1, 1, 9'h033, 0);
    tick;
    checks++;
    if (ia.loading !== 1'b0 || ia.load_count !== 13'd0 || ia.in_ready !== 1'b0 || ia.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: got loading=%0b count=%0d ready=%0b wr_en=%0b expected 0 0 0 0",
               ia.loading, ia.load_count, ia.in_ready, ia.wr_en);
    end
    reset_n = 1'b1;
    set_a(1, 0, 9'h0, 0);
    tick;
    checks++;
    if (ia.loading !== 1'b1) begin
      errors++;
      $display("FAIL midrst_restart: got loading=%0b expected 1", ia.loading);
    end
    set_a(0, 1, 9'h044, 1);
    qa.push_back({12'd0, 9'h044});
    tick;
    set_a(0, 0, 9'h0, 0);
    checks++;
    if (ia.core_start !== 1'b1 || ia.load_count !== 13'd1 || ia.wr_addr !== 12'd0) begin
      errors++;
      $display("FAIL midrst_reload: got cs=%0b count=%0d addr=%0h expected 1 1 0",
               ia.core_start, ia.load_count, ia.wr_addr);
    end
    tick;
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL midrst_writes_missing: got %0d pending expected 0", qa.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_overflow();
    test_full_memory();
    test_reset_mid_load();
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
